// File: rtl/kernel_int_receiver.sv
// kernel_int_receiver
//
// Purpose:
//   Core-side end of the external interrupt handshake. A one-cycle (IO-domain)
//   request pulse on K_IntReq, tagged by K_IntID, is synchronized into the
//   core clock domain and edge-detected. The captured request is held pending
//   until the pipeline takes it. Normal IRQs are masked by IntEnable; urgent
//   requests (URQ) are never masked. Taking a request toggles I_IntAck, which
//   the controller edge-detects to clear its status bit.
//
// Parameters:
//   SYNC_STAGES : flops in each input synchronizer chain (must be >= 2)
//
// Ports:
//   Clock       in   core clock
//   Reset       in   asynchronous active-low reset
//   K_IntReq    in   request pulse from controller (asynchronous to Clock)
//   K_IntID     in   request class: 0 = IRQ, 1 = URQ (stable around the pulse)
//   IntEnable   in   core interrupt enable; masks IRQ only
//   IntTaken    in   pipeline commits interrupt entry this cycle
//   IntPending  out  interrupt request to pipeline (combinational)
//   IntUrgent   out  class of the pending or last-taken request
//   I_IntAck    out  toggle acknowledge to controller
//   Busy        out  request captured and not yet acknowledged
//   OverrunClr  in   (KINT_OVERRUN_DETECT_EN only) pulse clears Overrun
//   Overrun     out  (KINT_OVERRUN_DETECT_EN only) sticky: request seen while busy
//
// Configuration macro:
//   KINT_OVERRUN_DETECT_EN - when defined, adds Overrun/OverrunClr. When
//   undefined, requests arriving outside IDLE are silently dropped.

module kernel_int_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic K_IntReq,
    input  logic K_IntID,
    input  logic IntEnable,
    input  logic IntTaken,
`ifdef KINT_OVERRUN_DETECT_EN
    input  logic OverrunClr,
    output logic Overrun,
`endif
    output logic IntPending,
    output logic IntUrgent,
    output logic I_IntAck,
    output logic Busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StAck     = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers. Both chains have equal length so the class bit
    // arrives at the last stage together with the request it belongs to.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_id_sync;
    logic                   r_req_sync_last;

    logic w_req_sync;
    logic w_id_sync;
    logic w_rise;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_req_sync      <= '0;
            r_id_sync       <= '0;
            r_req_sync_last <= 1'b0;
        end else begin
            r_req_sync      <= {r_req_sync[SYNC_STAGES-2:0], K_IntReq};
            r_id_sync       <= {r_id_sync[SYNC_STAGES-2:0], K_IntID};
            r_req_sync_last <= r_req_sync[SYNC_STAGES-1];
        end
    end

    assign w_req_sync = r_req_sync[SYNC_STAGES-1];
    assign w_id_sync  = r_id_sync[SYNC_STAGES-1];
    // The pulse is seen high for several core cycles; only its leading edge
    // counts as a request.
    assign w_rise     = w_req_sync & ~r_req_sync_last;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_e r_state;
    state_e w_state_next;

    logic r_int_urgent;
    logic r_int_ack;
    logic r_busy;

    logic w_pending;
    logic w_take;
    logic w_capture;
    logic w_urgent_next;
    logic w_ack_next;
    logic w_busy_next;

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A rise outside IDLE never changes state, which also
    // covers a rise coinciding with IntTaken: the take wins.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_next = StPending;
                end
            end
            StPending: begin
                if (w_take) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output logic. IntPending is deliberately combinational so that an IRQ
    // held while masked is presented in the same cycle IntEnable rises.
    always_comb begin
        w_pending     = (r_state == StPending) & (r_int_urgent | IntEnable);
        // IntTaken is only meaningful while a request is actually presented.
        w_take        = w_pending & IntTaken;
        w_capture     = (r_state == StIdle) & w_rise;

        w_urgent_next = r_int_urgent;
        w_ack_next    = r_int_ack;
        w_busy_next   = r_busy;

        if (w_capture) begin
            w_urgent_next = w_id_sync;
            w_busy_next   = 1'b1;
        end
        if (w_take) begin
            w_ack_next = ~r_int_ack;
        end
        if (r_state == StAck) begin
            w_busy_next = 1'b0;
        end
    end

    // Registered outputs. IntUrgent keeps the last captured class after the
    // handshake completes so software can still read it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_int_urgent <= 1'b0;
            r_int_ack    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_int_urgent <= w_urgent_next;
            r_int_ack    <= w_ack_next;
            r_busy       <= w_busy_next;
        end
    end

    assign IntPending = w_pending;
    assign IntUrgent  = r_int_urgent;
    assign I_IntAck   = r_int_ack;
    assign Busy       = r_busy;

`ifdef KINT_OVERRUN_DETECT_EN
    // ------------------------------------------------------------------
    // Overrun detection: a new request edge while a handshake is still in
    // progress means the controller broke protocol. Sticky until cleared;
    // a simultaneous set beats the clear so no event is lost.
    // ------------------------------------------------------------------
    logic r_overrun;
    logic w_overrun_set;

    assign w_overrun_set = w_rise & (r_state != StIdle);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (OverrunClr) begin
            r_overrun <= 1'b0;
        end
    end

    assign Overrun = r_overrun;
`endif

endmodule
